// File: rtl/core_fetch_prefetch.sv
// Instruction prefetch queue: issues single-outstanding word reads on a
// strobe/response bus and buffers returned instructions for the issue stage.
// Supports redirect (flush), halt, and stops fetching after a faulted response.
module core_fetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [29:0] target,
  input  logic        halt,
  input  logic        consume,
  output logic        fetch_start,
  output logic [29:0] fetch_addr,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        fetch_fault,
  output logic [31:0] insn,
  output logic [29:0] insn_pc,
  output logic        insn_abort,
  output logic        bubble
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // control state
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [29:0]   ptr_q, ptr_d;
  logic [29:0]   req_addr_q, req_addr_d;
  logic          outst_q, outst_d;
  logic          discard_q, discard_d;
  logic          stopped_q, stopped_d;

  // queue storage
  logic [31:0]   data_q  [DEPTH];
  logic [29:0]   pc_q    [DEPTH];
  logic          abort_q [DEPTH];

  logic          resp_live;
  logic          resp_fault;
  logic          enq;
  logic          deq;
  logic          busy;
  logic          empty;
  logic [CW:0]   occ;

  // A response is live only for a request that was not discarded by a flush.
  assign resp_live  = fetch_ready & outst_q & ~discard_q;
  assign resp_fault = resp_live & fetch_fault;
  assign enq        = resp_live & ~flush;
  assign empty      = (count_q == '0);
  assign deq        = consume & ~empty & ~flush;
  // A discarded request keeps the bus busy through its response cycle, so a
  // post-flush fetch cannot start until the cycle after it.
  assign busy       = outst_q & ~resp_live;
  // Occupancy reserves a slot for a live in-flight request so the queue
  // can never overflow when its response lands.
  assign occ        = {1'b0, count_q} + (CW+1)'(outst_q & ~discard_q) - (CW+1)'(deq);

  assign fetch_start = rst_n & ~busy & ~halt & ~flush & ~stopped_q & ~resp_fault
                       & (occ < DEPTH[CW:0]);
  assign fetch_addr  = ptr_q;

  // Head outputs come straight from queue registers; faulted entries store zero data.
  assign bubble     = empty;
  assign insn       = empty ? 32'h0 : data_q[rd_q];
  assign insn_pc    = empty ? 30'h0 : pc_q[rd_q];
  assign insn_abort = empty ? 1'b0  : abort_q[rd_q];

  // Next-state computation for pointers, counters and bus-tracking flags.
  always_comb begin
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ptr_d      = ptr_q;
    req_addr_d = req_addr_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    stopped_d  = stopped_q;

    if (flush) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      ptr_d   = target;
    end else begin
      count_d = count_q + CW'(enq) - CW'(deq);
      rd_d    = rd_q + AW'(deq);
      wr_d    = wr_q + AW'(enq);
      if (fetch_start) begin
        ptr_d      = ptr_q + 30'd1;
        req_addr_d = ptr_q;
      end
    end

    if (fetch_ready & outst_q) begin
      outst_d   = 1'b0;
      discard_d = 1'b0;
    end
    if (fetch_start) outst_d = 1'b1;
    if (flush & outst_q & ~fetch_ready) discard_d = 1'b1;

    if (flush) stopped_d = 1'b0;
    else if (resp_fault) stopped_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      ptr_q      <= RESET_PC;
      req_addr_q <= '0;
      outst_q    <= 1'b0;
      discard_q  <= 1'b0;
      stopped_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ptr_q      <= ptr_d;
      req_addr_q <= req_addr_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      stopped_q  <= stopped_d;
    end
  end

  // Queue write port: one entry per live, non-flushed response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        pc_q[i]    <= '0;
        abort_q[i] <= 1'b0;
      end
    end else if (enq) begin
      data_q[wr_q]  <= fetch_fault ? 32'h0 : fetch_data;
      pc_q[wr_q]    <= req_addr_q;
      abort_q[wr_q] <= fetch_fault;
    end
  end

endmodule

// File: tb/tb_core_fetch_prefetch.sv
// Directed bench for core_fetch_prefetch with a 1-cycle auto-responding bus
// and a manually driven bus for flush/halt/reset corner cases.
module tb_core_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [29:0] target;
  logic        halt;
  logic        consume;
  logic        fetch_start;
  logic [29:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic [31:0] insn;
  logic [29:0] insn_pc;
  logic        insn_abort;
  logic        bubble;

  logic        bus_en;
  logic [29:0] fault_addr;
  logic        auto_ready = 1'b0;
  logic [31:0] auto_data  = 32'h0;
  logic        auto_fault = 1'b0;
  logic        man_ready;
  logic [31:0] man_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign fetch_ready = bus_en ? auto_ready : man_ready;
  assign fetch_data  = bus_en ? auto_data  : man_data;
  assign fetch_fault = bus_en ? auto_fault : 1'b0;

  core_fetch_prefetch #(.DEPTH(4), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .target(target), .halt(halt),
    .consume(consume), .fetch_start(fetch_start), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .insn(insn), .insn_pc(insn_pc), .insn_abort(insn_abort), .bubble(bubble)
  );

  // 1-cycle latency bus: data is {2'b10, addr}
  always @(posedge clk) begin
    auto_ready <= 1'b0;
    if (bus_en && fetch_start) begin
      auto_ready <= 1'b1;
      auto_data  <= {2'b10, fetch_addr};
      auto_fault <= (fetch_addr == fault_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; target = '0; halt = 1'b0; consume = 1'b0;
    bus_en = 1'b1; fault_addr = 30'h3FFF0000; man_ready = 1'b0; man_data = '0;
    tick(); tick();
    smp();
    chk("rst_bubble", 32'(bubble), 32'd1);
    chk("rst_insn", insn, 32'h0);
    chk("rst_pc", 32'(insn_pc), 32'h0);
    chk("rst_abort", 32'(insn_abort), 32'd0);
    chk("rst_start", 32'(fetch_start), 32'd0);
    tick();
    rst_n = 1'b1;

    // fill from reset, no consume
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("fill_start", 32'(fetch_start), 32'd1);
      chk("fill_addr", 32'(fetch_addr), 32'(i));
      tick();
    end
    smp();
    chk("full_nostart0", 32'(fetch_start), 32'd0);
    tick();
    smp();
    chk("full_nostart1", 32'(fetch_start), 32'd0);
    chk("full_bubble", 32'(bubble), 32'd0);
    chk("full_pc", 32'(insn_pc), 32'h0);
    chk("full_insn", insn, 32'h80000000);
    tick();

    // streaming with consume every cycle
    consume = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("stream_pc", 32'(insn_pc), 32'(i));
      chk("stream_start", 32'(fetch_start), 32'd1);
      chk("stream_addr", 32'(fetch_addr), 32'(4 + i));
      tick();
    end
    consume = 1'b0;
    idle(4);

    // pointer wrap
    flush = 1'b1; target = 30'h3FFFFFFE;
    smp();
    chk("wrap_flush_nostart", 32'(fetch_start), 32'd0);
    tick();
    flush = 1'b0;
    smp();
    chk("wrap_bubble", 32'(bubble), 32'd1);
    chk("wrap_addr0", 32'(fetch_addr), 32'h3FFFFFFE);
    tick();
    smp();
    chk("wrap_addr1", 32'(fetch_addr), 32'h3FFFFFFF);
    tick();
    smp();
    chk("wrap_start2", 32'(fetch_start), 32'd1);
    chk("wrap_addr2", 32'(fetch_addr), 32'h0);
    idle(6);

    // flush in the same cycle as the response
    bus_en = 1'b0;
    flush = 1'b1; target = 30'd5;
    smp();
    tick();
    flush = 1'b0;
    smp();
    chk("fr_start5", 32'(fetch_start), 32'd1);
    chk("fr_addr5", 32'(fetch_addr), 32'd5);
    tick();
    man_ready = 1'b1; man_data = 32'hDEAD0005; flush = 1'b1; target = 30'h100;
    smp();
    chk("fr_flush_nostart", 32'(fetch_start), 32'd0);
    tick();
    man_ready = 1'b0; flush = 1'b0; bus_en = 1'b1;
    smp();
    chk("fr_bubble0", 32'(bubble), 32'd1);
    chk("fr_start100", 32'(fetch_start), 32'd1);
    chk("fr_addr100", 32'(fetch_addr), 32'h100);
    tick();
    smp();
    chk("fr_bubble1", 32'(bubble), 32'd1);
    tick();
    smp();
    chk("fr_bubble2", 32'(bubble), 32'd0);
    chk("fr_pc", 32'(insn_pc), 32'h100);
    chk("fr_insn", insn, 32'h80000100);
    idle(6);

    // flush with request outstanding, back-to-back flushes
    bus_en = 1'b0;
    flush = 1'b1; target = 30'h200;
    smp();
    tick();
    flush = 1'b0;
    smp();
    chk("dc_addr200", 32'(fetch_addr), 32'h200);
    chk("dc_start200", 32'(fetch_start), 32'd1);
    tick();
    flush = 1'b1; target = 30'h280;
    smp();
    tick();
    target = 30'h300;
    smp();
    chk("dc_flush2_nostart", 32'(fetch_start), 32'd0);
    tick();
    flush = 1'b0;
    smp();
    chk("dc_busy_nostart", 32'(fetch_start), 32'd0);
    tick();
    man_ready = 1'b1; man_data = 32'hBAD00200;
    smp();
    chk("dc_resp_nostart", 32'(fetch_start), 32'd0);
    tick();
    man_ready = 1'b0; bus_en = 1'b1;
    smp();
    chk("dc_start300", 32'(fetch_start), 32'd1);
    chk("dc_addr300", 32'(fetch_addr), 32'h300);
    chk("dc_bubble", 32'(bubble), 32'd1);
    tick();
    idle(6);

    // faulted response at address 7
    fault_addr = 30'd7;
    flush = 1'b1; target = 30'd5;
    smp();
    tick();
    flush = 1'b0;
    for (int i = 5; i < 8; i++) begin
      smp();
      chk("ft_start", 32'(fetch_start), 32'd1);
      chk("ft_addr", 32'(fetch_addr), 32'(i));
      tick();
    end
    smp();
    chk("ft_stop0", 32'(fetch_start), 32'd0);
    tick();
    smp();
    chk("ft_stop1", 32'(fetch_start), 32'd0);
    tick();
    consume = 1'b1;
    smp();
    chk("ft_pc5", 32'(insn_pc), 32'd5);
    chk("ft_insn5", insn, 32'h80000005);
    tick();
    smp();
    chk("ft_pc6", 32'(insn_pc), 32'd6);
    tick();
    consume = 1'b0;
    smp();
    chk("ft_pc7", 32'(insn_pc), 32'd7);
    chk("ft_abort", 32'(insn_abort), 32'd1);
    chk("ft_insn0", insn, 32'h0);
    chk("ft_bubble", 32'(bubble), 32'd0);
    chk("ft_stop2", 32'(fetch_start), 32'd0);
    tick();
    flush = 1'b1; target = 30'h40; fault_addr = 30'h3FFF0000;
    smp();
    tick();
    flush = 1'b0;
    smp();
    chk("ft_restart", 32'(fetch_start), 32'd1);
    chk("ft_restart_addr", 32'(fetch_addr), 32'h40);
    idle(6);

    // halt with a request outstanding
    bus_en = 1'b0;
    flush = 1'b1; target = 30'h20;
    smp();
    tick();
    flush = 1'b0;
    smp();
    chk("ht_start", 32'(fetch_start), 32'd1);
    chk("ht_addr", 32'(fetch_addr), 32'h20);
    tick();
    halt = 1'b1;
    smp();
    chk("ht_nostart0", 32'(fetch_start), 32'd0);
    tick();
    man_ready = 1'b1; man_data = 32'hCAFE0020;
    smp();
    chk("ht_nostart1", 32'(fetch_start), 32'd0);
    tick();
    man_ready = 1'b0;
    smp();
    chk("ht_nostart2", 32'(fetch_start), 32'd0);
    chk("ht_bubble", 32'(bubble), 32'd0);
    chk("ht_insn", insn, 32'hCAFE0020);
    chk("ht_pc", 32'(insn_pc), 32'h20);
    tick();
    halt = 1'b0;
    smp();
    chk("ht_resume", 32'(fetch_start), 32'd1);
    chk("ht_resume_addr", 32'(fetch_addr), 32'h21);
    tick();
    man_ready = 1'b1; man_data = 32'h0; halt = 1'b1;
    smp();
    tick();
    man_ready = 1'b0;
    idle(2);

    // reset mid-transfer, stale response after release
    halt = 1'b0;
    flush = 1'b1; target = 30'h50;
    smp();
    tick();
    flush = 1'b0;
    smp();
    chk("rs_start", 32'(fetch_start), 32'd1);
    chk("rs_addr", 32'(fetch_addr), 32'h50);
    tick();
    rst_n = 1'b0;
    smp();
    chk("rs_bubble", 32'(bubble), 32'd1);
    chk("rs_nostart", 32'(fetch_start), 32'd0);
    chk("rs_pc", 32'(insn_pc), 32'h0);
    chk("rs_insn", insn, 32'h0);
    tick();
    rst_n = 1'b1; halt = 1'b1; man_ready = 1'b1; man_data = 32'h11111111;
    smp();
    chk("rs_halt_nostart", 32'(fetch_start), 32'd0);
    tick();
    man_ready = 1'b0;
    smp();
    chk("rs_stale_ignored", 32'(bubble), 32'd1);
    tick();
    halt = 1'b0;
    smp();
    chk("rs_first_start", 32'(fetch_start), 32'd1);
    chk("rs_first_addr", 32'(fetch_addr), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
